// File: rtl/jelly_wishbone_cmd_master.sv
// Wishbone classic single-transfer master: valid/ready command in, valid/ready response out.
// Optional JELLY_WISHBONE_CMD_MASTER_FASTPATH_EN lets a new command be accepted while the response is consumed.
module jelly_wishbone_cmd_master #(
    parameter int unsigned WB_ADR_WIDTH   = 16,
    parameter int unsigned WB_DAT_WIDTH   = 32,
    parameter int unsigned WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
    parameter int unsigned TIMEOUT_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic                    cke,

    input  logic                    s_cmd_we,
    input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
    input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
    input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,

    output logic                    m_rsp_we,
    output logic [WB_DAT_WIDTH-1:0] m_rsp_dat,
    output logic                    m_rsp_err,
    output logic                    m_rsp_valid,
    input  logic                    m_rsp_ready,

    output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
    input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
    output logic                    m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i,

    output logic                    busy
);

    localparam bit                     TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [TIMEOUT_WIDTH-1:0] to_cnt;
    logic                     cmd_load;
    logic                     rsp_ack;
    logic                     rsp_timeout;
    logic                     cnt_inc;
    logic                     cmd_ready_c;

    // State register; cke freezes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (cke) begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_next  = state;
        cmd_load    = 1'b0;
        rsp_ack     = 1'b0;
        rsp_timeout = 1'b0;
        cnt_inc     = 1'b0;
        cmd_ready_c = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                if (s_cmd_valid) begin
                    cmd_load   = 1'b1;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                if (m_wb_ack_i) begin
                    rsp_ack    = 1'b1;
                    state_next = ST_RESP;
                end else if (TIMEOUT_EN && (to_cnt == TO_LAST)) begin
                    rsp_timeout = 1'b1;
                    state_next  = ST_RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_RESP: begin
`ifdef JELLY_WISHBONE_CMD_MASTER_FASTPATH_EN
                cmd_ready_c = m_rsp_ready;
                if (m_rsp_ready) begin
                    if (s_cmd_valid) begin
                        cmd_load   = 1'b1;
                        state_next = ST_BUS;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
`else
                if (m_rsp_ready) begin
                    state_next = ST_IDLE;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command capture, timeout counter and response payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wb_adr_o <= '0;
            m_wb_dat_o <= '0;
            m_wb_we_o  <= 1'b0;
            m_wb_sel_o <= '0;
            to_cnt     <= '0;
            m_rsp_we   <= 1'b0;
            m_rsp_dat  <= '0;
            m_rsp_err  <= 1'b0;
        end else if (cke) begin
            if (cmd_load) begin
                m_wb_adr_o <= s_cmd_adr;
                m_wb_dat_o <= s_cmd_dat;
                m_wb_we_o  <= s_cmd_we;
                m_wb_sel_o <= s_cmd_sel;
                to_cnt     <= '0;
            end else if (cnt_inc) begin
                to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
            end
            if (rsp_ack) begin
                m_rsp_we  <= m_wb_we_o;
                m_rsp_dat <= m_wb_we_o ? '0 : m_wb_dat_i;
                m_rsp_err <= 1'b0;
            end else if (rsp_timeout) begin
                m_rsp_we  <= m_wb_we_o;
                m_rsp_dat <= '0;
                m_rsp_err <= 1'b1;
            end
        end
    end

    // Handshake and strobe flags decode straight from the state register
    assign s_cmd_ready = cmd_ready_c;
    assign m_wb_stb_o  = (state == ST_BUS);
    assign m_rsp_valid = (state == ST_RESP);
    assign busy        = (state != ST_IDLE);

endmodule

// File: doc/jelly_wishbone_cmd_master.md
Name: jelly_wishbone_cmd_master

Overview:
- Wishbone classic single-transfer master; the initiator side for Wishbone slave register blocks such as the RTOS core.
- Converts a valid/ready command stream (read/write, address, data, select) into one Wishbone cycle.
- Returns a valid/ready response carrying read data and an error flag.
- One transaction outstanding at a time; a bus timeout guards against slaves that never ack.

Parameters:
WB_ADR_WIDTH, 16, Wishbone word address width
WB_DAT_WIDTH, 32, Wishbone data width
WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width
TIMEOUT_WIDTH, 8, timeout counter width
TIMEOUT_CYCLES, 255, max cycles stb is held without ack; 0 disables timeout (must fit TIMEOUT_WIDTH)

Ports:
reset  input  1  asynchronous active-low reset (asserted at 0)
clk  input  1  clock
cke  input  1  clock enable; 0 freezes all state
s_cmd_we  input  1  1=write, 0=read
s_cmd_adr  input  WB_ADR_WIDTH  target address
s_cmd_dat  input  WB_DAT_WIDTH  write data
s_cmd_sel  input  WB_SEL_WIDTH  byte selects
s_cmd_valid  input  1  command valid
s_cmd_ready  output  1  command accepted when valid&ready&cke
m_rsp_we  output  1  echo of command we
m_rsp_dat  output  WB_DAT_WIDTH  read data (0 for writes and timeouts)
m_rsp_err  output  1  1=timeout
m_rsp_valid  output  1  response valid
m_rsp_ready  input  1  response consumed when valid&ready&cke
m_wb_adr_o  output  WB_ADR_WIDTH  Wishbone address
m_wb_dat_i  input  WB_DAT_WIDTH  Wishbone read data
m_wb_dat_o  output  WB_DAT_WIDTH  Wishbone write data
m_wb_we_o  output  1  Wishbone write enable
m_wb_sel_o  output  WB_SEL_WIDTH  Wishbone byte select
m_wb_stb_o  output  1  Wishbone strobe (cyc implied)
m_wb_ack_i  input  1  Wishbone acknowledge
busy  output  1  state != IDLE

Behaviour:
- All registers are asynchronously cleared on reset=0. All outputs reset to 0 except s_cmd_ready, which is 1 once reset is released and state is IDLE.
- States: IDLE, BUS, RESP. All transitions, counters and captures happen only on clk edges with cke=1.
- IDLE: s_cmd_ready=1. On s_cmd_valid:
  - latch adr, dat, sel and we into m_wb_* registers;
  - clear the timeout counter;
  - go to BUS.
- BUS: m_wb_stb_o=1 and s_cmd_ready=0. m_wb_adr_o, dat_o, we_o and sel_o stay stable for the whole state.
  - If m_wb_ack_i=1: m_rsp_dat<=(we ? 0 : m_wb_dat_i), m_rsp_err<=0, m_rsp_we<=we, deassert stb, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: m_rsp_dat<=0, m_rsp_err<=1, deassert stb, go to RESP.
  - Else counter increments by 1.
  - If ack and the timeout threshold occur in the same cycle, ack wins (err=0).
- RESP: m_rsp_valid=1 with payload held stable until m_rsp_ready=1, then go to IDLE.
- Latency:
  - command accepted at edge N → stb high from cycle N+1;
  - ack sampled at edge M → m_rsp_valid high from cycle M+1.
- Minimum command period is 3 cycles with a zero-wait slave.
- m_wb_stb_o never asserts outside BUS. A timeout leaves stb high for exactly TIMEOUT_CYCLES cycles.
- An ack arriving while not in BUS is ignored.
- Reset mid-transaction aborts immediately: stb=0 and rsp_valid=0, with no response emitted.
- cke=0 holds state, counter and all outputs; handshakes do not complete.

Optional Feature:
- Macro: JELLY_WISHBONE_CMD_MASTER_FASTPATH_EN.
- When defined:
  - in RESP, s_cmd_ready=m_rsp_ready;
  - a simultaneous response handshake and command acceptance goes directly RESP→BUS, latching the new command;
  - minimum command period is 2 cycles.
- When undefined: s_cmd_ready=0 in RESP and every command passes through IDLE.
- Reset values and response content are identical in both builds.

Test Plan:
- Write: cmd we=1, adr=0x0010, dat=0xA5A5_0001, sel=0xF; slave acks 1 cycle after stb → one stb cycle with those values; rsp valid err=0, dat=0, we=1, exactly 1 cycle after ack.
- Read with 3 wait states: slave returns 0x1234_5678 → stb held 4 cycles with stable adr; rsp dat=0x1234_5678, err=0.
- Timeout, TIMEOUT_CYCLES=4, no ack → stb high exactly 4 cycles; rsp err=1, dat=0. Ack on the 4th cycle → err=0 instead.
- Backpressure: m_rsp_ready=0 for 5 cycles → rsp_valid and payload stable, s_cmd_ready=0, stb=0. Ten back-to-back commands with zero-wait ack → period 3 cycles (2 with FASTPATH_EN).
- cke=0 for 3 cycles during BUS with TIMEOUT_CYCLES=4, no ack → timeout still after 4 enabled cycles; outputs frozen while cke=0.
- reset=0 asserted asynchronously mid-BUS → stb, rsp_valid, busy drop immediately; after release s_cmd_ready=1 and a subsequent read completes normally.
